// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arb_defs: shared definitions for the FIFO write-side arbiter.
// Holds the two-state write FSM encoding used by fifo_wr_arbiter.
package fifo_wr_arb_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PUSH = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports: req (request vector), last (previous winner),
//        pick (first requester after last, wrapping), any_req (|req).
module rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic [IDW-1:0]     pick,
  output logic               any_req
);

  logic found;
  int   idx;

  // Walk last+1, last+2, ... with wrap; the first
  // requester seen wins, so last itself has lowest
  // priority.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        pick  = idx[IDW-1:0];
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin scheduler for one async-FIFO write port.
// Ports: wclk/wrst, req_valid/req_data/req_ready (requesters), wfull,
//        winc/wr_data (FIFO), grant_id, busy, full_stall_cnt (status).
module fifo_wr_arbiter
  import fifo_wr_arb_defs::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int DATA_WIDTH = 8,
  parameter  int CNT_WIDTH  = 16,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          full_stall_cnt
);

  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    ready_q, ready_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]        gid_q, gid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [IDW-1:0] pick;
  logic           any_req;
  logic           stall;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req_valid),
    .last    (gid_q),
    .pick    (pick),
    .any_req (any_req)
  );

  assign stall = any_req && wfull;

  always_comb begin
    state_d = state_q;
    ready_d = '0;
    data_d  = data_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;

    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + CNT_WIDTH'(1);

    unique case (state_q)
      ST_IDLE: begin
        // wfull is only trusted here: the cycle
        // after a push the pointer has settled.
        if (!wfull && any_req) begin
          state_d       = ST_PUSH;
          ready_d[pick] = 1'b1;
          data_d        = req_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          gid_d         = pick;
        end
      end
      ST_PUSH: begin
        // Forced low cycle keeps winc edge-detectable.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= ST_IDLE;
      ready_q <= '0;
      data_q  <= '0;
      gid_q   <= IDW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign winc           = (state_q == ST_PUSH);
  assign busy           = (state_q == ST_PUSH);
  assign req_ready      = ready_q;
  assign wr_data        = data_q;
  assign grant_id       = gid_q;
  assign full_stall_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter.
// Directed scenarios followed by randomized traffic.
module tb_fifo_wr_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int IW = 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          wclk = 1'b0;
  logic          wrst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          wfull = 1'b0;
  logic          winc;
  logic [DW-1:0] wr_data;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic [CW-1:0] full_stall_cnt;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .wclk           (wclk),
    .wrst           (wrst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .wfull          (wfull),
    .winc           (winc),
    .wr_data        (wr_data),
    .grant_id       (grant_id),
    .busy           (busy),
    .full_stall_cnt (full_stall_cnt)
  );

  typedef struct {
    int            cyc;
    int            id;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;
  int m_last = N - 1;
  int m_cnt  = 0;
  int m_last_wr = -10;
  logic prev_w = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               name, act, exp, edge_n);
    end
  endtask

  // Reference model: one write per grant, at most one
  // write every other edge, rotating priority.
  initial forever begin
    @(posedge wclk);
    edge_n++;
    if (wrst) begin
      m_last    = N - 1;
      m_cnt     = 0;
      m_last_wr = -10;
      exp_q.delete();
    end else begin
      if (|req_valid && wfull && m_cnt < CMAX)
        m_cnt++;
      if (m_last_wr != edge_n - 1 && !wfull && |req_valid) begin
        bit found;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (!found && req_valid[idx]) begin
            wr_t e;
            e.cyc  = edge_n;
            e.id   = idx;
            e.data = req_data[idx*DW +: DW];
            exp_q.push_back(e);
            m_last    = idx;
            m_last_wr = edge_n;
            found     = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs with the model.
  initial forever begin
    @(negedge wclk);
    if (edge_n > 0) begin
      bit ew;
      ew = (exp_q.size() > 0) && (exp_q[0].cyc == edge_n);
      chk("winc", winc, ew);
      chk("busy", busy, ew);
      chk("winc_back2back", winc & prev_w, 0);
      chk("ready_onehot0", $onehot0(req_ready), 1);
      chk("grant_id", grant_id, m_last);
      chk("stall_cnt", full_stall_cnt, m_cnt);
      if (ew) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_data", wr_data, e.data);
        chk("req_ready", req_ready, 1 << e.id);
      end else begin
        chk("req_ready_idle", req_ready, 0);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_n)
        void'(exp_q.pop_front());
      prev_w = winc;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge wclk);
  endtask

  task automatic wait_winc();
    int t;
    t = 0;
    while (winc !== 1'b1 && t < 20) begin
      @(negedge wclk);
      t++;
    end
    chk("wait_winc", winc, 1);
  endtask

  initial begin
    wrst = 1'b1;
    cyc(2);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_grant", grant_id, N - 1);
    wrst = 1'b0;

    // single requester
    req_data[7:0] = 8'hA5;
    req_valid     = 2'b01;
    cyc(1);
    req_valid = 2'b00;
    cyc(3);

    // both requesters, alternating grants
    req_data  = {8'h22, 8'h11};
    req_valid = 2'b11;
    cyc(8);
    req_valid = 2'b00;
    cyc(2);

    // full blocks grants, counter counts
    wfull     = 1'b1;
    req_valid = 2'b11;
    cyc(5);
    chk("stall5", full_stall_cnt, 5);
    wfull = 1'b0;
    cyc(3);
    req_valid = 2'b00;
    cyc(2);

    // wfull rises during push
    req_data[7:0] = 8'h3C;
    req_valid     = 2'b01;
    wait_winc();
    wfull = 1'b1;
    cyc(3);
    wfull = 1'b0;
    cyc(3);
    req_valid = 2'b00;
    cyc(2);

    // reset in the middle of a push
    req_valid = 2'b11;
    wait_winc();
    wrst = 1'b1;
    cyc(1);
    chk("midrst_grant", grant_id, N - 1);
    chk("midrst_cnt", full_stall_cnt, 0);
    chk("midrst_winc", winc, 0);
    wrst = 1'b0;
    cyc(3);
    req_valid = 2'b00;
    cyc(2);

    // counter saturation
    wfull     = 1'b1;
    req_valid = 2'b01;
    cyc(20);
    chk("stall_sat", full_stall_cnt, CMAX);
    wfull     = 1'b0;
    req_valid = 2'b00;
    cyc(3);

    // randomized traffic
    repeat (400) begin
      @(negedge wclk);
      req_valid = N'($urandom);
      req_data  = (N*DW)'($urandom);
      wfull     = ($urandom_range(0, 3) == 0);
      wrst      = ($urandom_range(0, 79) == 0);
    end
    wrst      = 1'b0;
    wfull     = 1'b0;
    req_valid = '0;
    cyc(4);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
